atm_multi_account: RTL and testbench
====================================

# atm_multi_account

Parametrised multi-account ATM transaction engine. It holds a table of NUM_ACCOUNTS accounts, each with a PIN, a balance, a failed-attempt counter and a lock flag. It executes one operation per start/done handshake: login, balance, withdraw, deposit, transfer or change-PIN. Compared with the fixed single-session ATM controller, it adds configurable widths and depth, PIN-retry lockout, PIN change, explicit error codes and a latency-fixed handshake.

## Interface
- NUM_ACCOUNTS, 8: number of accounts; account i has number ACC_BASE+i.
- ACC_W, 12: account-number width.
- ACC_BASE, 2176: account number of index 0.
- PIN_W, 4: PIN width.
- PIN_OFFSET, 2: reset PIN of account i is (i+PIN_OFFSET) mod 2^PIN_W.
- BAL_W, 11: balance and amount width.
- INIT_BALANCE, 500: reset balance of every account.
- MAX_TRIES, 3: consecutive wrong PINs that lock an account.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe, sampled only in IDLE.
- exit  in  1  logout request, sampled only in IDLE.
- acc_number  in  ACC_W  account number for LOGIN.
- pin  in  PIN_W  PIN for LOGIN and CHANGE_PIN.
- dest_acc_number  in  ACC_W  TRANSFER destination.
- op  in  3  0 LOGIN, 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 TRANSFER, 5 CHANGE_PIN, 6–7 invalid.
- amount  in  BAL_W  operand for WITHDRAW, DEPOSIT and TRANSFER.
- new_pin  in  PIN_W  replacement PIN for CHANGE_PIN.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.
- error  out  1  high when err_code is not 0; holds until the next done.
- err_code  out  3  0 none, 1 account not found, 2 bad PIN, 3 locked, 4 insufficient funds, 5 overflow, 6 not logged in, 7 invalid op or self-transfer.
- logged_in  out  1  a session is active.
- locked  out  1  the last login target is locked.
- balance  out  BAL_W  balance of the session account.

## Operation
- FSM states: IDLE → CHECK → EXEC → DONE → IDLE. Only IDLE waits; every other state lasts one cycle.
- Operands are captured at the start edge. Later input changes are ignored.
- CHECK: look up acc_number or dest_acc_number (a valid hit is ACC_BASE ≤ n < ACC_BASE+NUM_ACCOUNTS) and evaluate all error conditions.
- EXEC: commit every table write on a single edge. An operation that ends in error writes nothing, except the fail-counter and lock updates below.
- Error precedence: 7 invalid op; 6 not logged in (applies to all ops except LOGIN); then op-specific checks.
- LOGIN:
  - Not found → 1.
  - Locked → 3.
  - PIN mismatch → 2; increment the fail counter, and on reaching MAX_TRIES set lock and assert locked.
  - Match → clear the fail counter, start the session, set balance.
  - Any failed LOGIN ends an existing session.
- WITHDRAW: amount > balance → 4; otherwise subtract.
- DEPOSIT: compute the sum at BAL_W+1 bits; sum > 2^BAL_W−1 → 5; otherwise store it.
- TRANSFER: checks in order:
  1. Destination not found → 1.
  2. Destination equals the session account → 7.
  3. amount > source balance → 4.
  4. Destination sum overflows → 5.
  
  Otherwise debit the source and credit the destination on the same edge.
- CHANGE_PIN: pin must equal the stored PIN, otherwise → 2 with the same fail-counter and lock rules as LOGIN. If that locks the account, the session ends. On success, write new_pin.
- amount = 0 is legal and leaves balances unchanged.
- balance output: updated at DONE to the post-op session balance; unchanged on error; 0 when logged out.
- exit in IDLE: clear logged_in, locked and balance on the next edge.
- exit and start high together in IDLE: exit wins and start is dropped.

## Timing
- Reset values:
  - Outputs: all 0; state IDLE.
  - Table: PINs and balances at their parameter values; fail counters 0; locks clear.
- start sampled at edge N:
  - busy is high from edge N to edge N+3.
  - done, error, err_code and balance are valid in the cycle after edge N+2.
- The next start is accepted at edge N+3 or later. start while busy is ignored.
- Reset mid-operation aborts the operation with no partial write; TRANSFER is atomic.

## Test plan
- Reset; LOGIN 2178 PIN 4 → done 3 cycles after start, err 0, logged_in 1, balance 500.
- WITHDRAW 100 → balance 400. Then WITHDRAW 2000 → err 4, balance stays 400.
- TRANSFER 50 to 2180 → balance 350. Then exit; LOGIN 2180 PIN 6 → balance 550. TRANSFER 10 to 2180 → err 7.
- On 2180: DEPOSIT 1500 → err 5, balance 550. Then DEPOSIT 1497 → balance 2047.
- LOGIN 2177 with PIN 0 three times → err 2 each time, locked=1 after the third. Then PIN 3 → err 3. Reset, then PIN 3 → success.
- BALANCE with no session → err 6. exit together with start → no done. start during busy → ignored. op 6 → err 7. Reset asserted during EXEC → balances unchanged.

Source files
------------

// File: rtl/atm_multi_account.sv
// Multi-account ATM transaction engine: an account table with PIN lockout,
// driven by a fixed-latency start/done handshake (IDLE -> CHECK -> EXEC -> DONE).
module atm_multi_account #(
  parameter int NUM_ACCOUNTS = 8,
  parameter int ACC_W        = 12,
  parameter int ACC_BASE     = 2176,
  parameter int PIN_W        = 4,
  parameter int PIN_OFFSET   = 2,
  parameter int BAL_W        = 11,
  parameter int INIT_BALANCE = 500,
  parameter int MAX_TRIES    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             exit,
  input  logic [ACC_W-1:0] acc_number,
  input  logic [PIN_W-1:0] pin,
  input  logic [ACC_W-1:0] dest_acc_number,
  input  logic [2:0]       op,
  input  logic [BAL_W-1:0] amount,
  input  logic [PIN_W-1:0] new_pin,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic             logged_in,
  output logic             locked,
  output logic [BAL_W-1:0] balance
);
  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int CNT_W = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] OP_LOGIN    = 3'd0;
  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT  = 3'd3;
  localparam logic [2:0] OP_TRANSFER = 3'd4;
  localparam logic [2:0] OP_CHPIN    = 3'd5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_NOACC   = 3'd1;
  localparam logic [2:0] ERR_PIN     = 3'd2;
  localparam logic [2:0] ERR_LOCKED  = 3'd3;
  localparam logic [2:0] ERR_FUNDS   = 3'd4;
  localparam logic [2:0] ERR_OVF     = 3'd5;
  localparam logic [2:0] ERR_SESSION = 3'd6;
  localparam logic [2:0] ERR_INVALID = 3'd7;

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic [PIN_W-1:0] pin_tab  [NUM_ACCOUNTS];
  logic [BAL_W-1:0] bal_tab  [NUM_ACCOUNTS];
  logic [CNT_W-1:0] fail_tab [NUM_ACCOUNTS];
  logic             lock_tab [NUM_ACCOUNTS];
  logic [IDX_W-1:0] sess_idx;

  logic             accept;
  logic [2:0]       op_p0;
  logic [ACC_W-1:0] acc_p0, dest_p0;
  logic [PIN_W-1:0] pin_p0, new_pin_p0;
  logic [BAL_W-1:0] amount_p0;

  logic [2:0]       err_p1;
  logic [IDX_W-1:0] tgt_p1, dst_p1;

  logic             acc_hit, dst_hit;
  logic [IDX_W-1:0] acc_idx, dst_idx, tgt_idx;
  logic [BAL_W-1:0] src_bal, sub_bal;
  logic [BAL_W:0]   dep_sum, dst_sum;
  logic [2:0]       err_chk;
  logic [CNT_W-1:0] fail_bump;
  logic             lock_hit;

  // Returns {hit, index}; numbers below the base wrap into the high half and miss.
  function automatic logic [IDX_W:0] lookup(input logic [ACC_W-1:0] n);
    logic [ACC_W:0] off;
    off = {1'b0, n} - (ACC_W+1)'(ACC_BASE);
    lookup = '0;
    if (off < (ACC_W+1)'(NUM_ACCOUNTS)) lookup = {1'b1, IDX_W'(off)};
  endfunction

  function automatic logic [BAL_W:0] add_wide(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    add_wide = {1'b0, a} + {1'b0, b};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !exit) begin
          accept    = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operands frozen at the accepting edge; p1: lookup and error verdict from CHECK
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0      <= op;
      acc_p0     <= acc_number;
      dest_p0    <= dest_acc_number;
      pin_p0     <= pin;
      new_pin_p0 <= new_pin;
      amount_p0  <= amount;
    end
    if (state == CHECK) begin
      err_p1 <= err_chk;
      tgt_p1 <= tgt_idx;
      dst_p1 <= dst_idx;
    end
  end

  always_comb begin
    {acc_hit, acc_idx} = lookup(acc_p0);
    {dst_hit, dst_idx} = lookup(dest_p0);
    tgt_idx   = (op_p0 == OP_LOGIN) ? acc_idx : sess_idx;
    src_bal   = bal_tab[sess_idx];
    sub_bal   = src_bal - amount_p0;
    dep_sum   = add_wide(src_bal, amount_p0);
    dst_sum   = add_wide(bal_tab[dst_idx], amount_p0);
    fail_bump = fail_tab[tgt_p1] + CNT_W'(1);
    lock_hit  = (fail_bump >= CNT_W'(MAX_TRIES));
    err_chk   = ERR_NONE;
    if (op_p0 > OP_CHPIN) err_chk = ERR_INVALID;
    else if (op_p0 != OP_LOGIN && !logged_in) err_chk = ERR_SESSION;
    else begin
      case (op_p0)
        OP_LOGIN: begin
          if (!acc_hit)                         err_chk = ERR_NOACC;
          else if (lock_tab[acc_idx])           err_chk = ERR_LOCKED;
          else if (pin_p0 != pin_tab[acc_idx])  err_chk = ERR_PIN;
        end
        OP_WITHDRAW: if (amount_p0 > src_bal) err_chk = ERR_FUNDS;
        OP_DEPOSIT:  if (dep_sum[BAL_W])      err_chk = ERR_OVF;
        OP_TRANSFER: begin
          if (!dst_hit)                 err_chk = ERR_NOACC;
          else if (dst_idx == sess_idx) err_chk = ERR_INVALID;
          else if (amount_p0 > src_bal) err_chk = ERR_FUNDS;
          else if (dst_sum[BAL_W])      err_chk = ERR_OVF;
        end
        OP_CHPIN: if (pin_p0 != pin_tab[sess_idx]) err_chk = ERR_PIN;
        default: ;
      endcase
    end
  end

  // EXEC edge: every table write and the DONE-cycle outputs land together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_tab[i]  <= PIN_W'(i + PIN_OFFSET);
        bal_tab[i]  <= BAL_W'(INIT_BALANCE);
        fail_tab[i] <= '0;
        lock_tab[i] <= 1'b0;
      end
      sess_idx  <= '0;
      done      <= 1'b0;
      err_code  <= ERR_NONE;
      logged_in <= 1'b0;
      locked    <= 1'b0;
      balance   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && exit) begin
        logged_in <= 1'b0;
        locked    <= 1'b0;
        balance   <= '0;
      end
      if (state == EXEC) begin
        done     <= 1'b1;
        err_code <= err_p1;
        if (err_p1 == ERR_PIN) begin
          fail_tab[tgt_p1] <= fail_bump;
          if (lock_hit) lock_tab[tgt_p1] <= 1'b1;
        end
        case (op_p0)
          OP_LOGIN: begin
            if (err_p1 == ERR_NONE) begin
              fail_tab[tgt_p1] <= '0;
              sess_idx         <= tgt_p1;
              logged_in        <= 1'b1;
              locked           <= 1'b0;
              balance          <= bal_tab[tgt_p1];
            end else begin
              logged_in <= 1'b0;
              balance   <= '0;
              locked    <= (err_p1 == ERR_LOCKED) || (err_p1 == ERR_PIN && lock_hit);
            end
          end
          OP_BALANCE: if (err_p1 == ERR_NONE) balance <= src_bal;
          OP_WITHDRAW: begin
            if (err_p1 == ERR_NONE) begin
              bal_tab[sess_idx] <= sub_bal;
              balance           <= sub_bal;
            end
          end
          OP_DEPOSIT: begin
            if (err_p1 == ERR_NONE) begin
              bal_tab[sess_idx] <= dep_sum[BAL_W-1:0];
              balance           <= dep_sum[BAL_W-1:0];
            end
          end
          OP_TRANSFER: begin
            if (err_p1 == ERR_NONE) begin
              bal_tab[sess_idx] <= sub_bal;
              bal_tab[dst_p1]   <= dst_sum[BAL_W-1:0];
              balance           <= sub_bal;
            end
          end
          OP_CHPIN: begin
            if (err_p1 == ERR_NONE) pin_tab[sess_idx] <= new_pin_p0;
            else if (err_p1 == ERR_PIN && lock_hit) begin
              logged_in <= 1'b0;
              locked    <= 1'b1;
              balance   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign error = (err_code != ERR_NONE);

endmodule

// File: tb/tb_atm_multi_account.sv
// Bench for atm_multi_account: directed scenarios plus randomized operations
// compared against an account-level reference model.
module tb_atm_multi_account;
  localparam int NUM     = 8;
  localparam int ACC_W   = 12;
  localparam int BASE    = 2176;
  localparam int PIN_W   = 4;
  localparam int PIN_OFF = 2;
  localparam int BAL_W   = 11;
  localparam int INIT    = 500;
  localparam int TRIES   = 3;
  localparam int BAL_MAX = (1 << BAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             exit = 1'b0;
  logic [ACC_W-1:0] acc_number = '0;
  logic [PIN_W-1:0] pin = '0;
  logic [ACC_W-1:0] dest_acc_number = '0;
  logic [2:0]       op = '0;
  logic [BAL_W-1:0] amount = '0;
  logic [PIN_W-1:0] new_pin = '0;
  logic             busy, done, error, logged_in, locked;
  logic [2:0]       err_code;
  logic [BAL_W-1:0] balance;

  int n_checks = 0;
  int n_errors = 0;

  int m_pin [NUM];
  int m_bal [NUM];
  int m_fail[NUM];
  int m_lock[NUM];
  int m_logged, m_locked, m_bal_out, m_sess;

  atm_multi_account #(
    .NUM_ACCOUNTS(NUM), .ACC_W(ACC_W), .ACC_BASE(BASE), .PIN_W(PIN_W),
    .PIN_OFFSET(PIN_OFF), .BAL_W(BAL_W), .INIT_BALANCE(INIT), .MAX_TRIES(TRIES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .exit(exit), .acc_number(acc_number),
    .pin(pin), .dest_acc_number(dest_acc_number), .op(op), .amount(amount),
    .new_pin(new_pin), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .logged_in(logged_in), .locked(locked), .balance(balance)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_pin[i]  = (i + PIN_OFF) % (1 << PIN_W);
      m_bal[i]  = INIT;
      m_fail[i] = 0;
      m_lock[i] = 0;
    end
    m_logged = 0; m_locked = 0; m_bal_out = 0; m_sess = 0;
  endtask

  task automatic model_exit();
    m_logged = 0; m_locked = 0; m_bal_out = 0;
  endtask

  // Bank-level rules: precedence, then per-operation outcome; returns the error code.
  task automatic model_op(input int o, input int a, input int p, input int d,
                          input int amt, input int np, output int e);
    int t, x, s;
    e = 0;
    s = m_sess;
    if (o > 5) e = 7;
    else if (o != 0 && m_logged == 0) e = 6;
    else if (o == 0) begin
      t = a - BASE;
      if (t < 0 || t >= NUM) begin
        e = 1; m_logged = 0; m_bal_out = 0; m_locked = 0;
      end else if (m_lock[t] != 0) begin
        e = 3; m_logged = 0; m_bal_out = 0; m_locked = 1;
      end else if (m_pin[t] != p) begin
        e = 2; m_fail[t]++;
        if (m_fail[t] >= TRIES) m_lock[t] = 1;
        m_logged = 0; m_bal_out = 0; m_locked = m_lock[t];
      end else begin
        m_fail[t] = 0; m_logged = 1; m_sess = t; m_locked = 0; m_bal_out = m_bal[t];
      end
    end else if (o == 1) m_bal_out = m_bal[s];
    else if (o == 2) begin
      if (amt > m_bal[s]) e = 4;
      else begin m_bal[s] -= amt; m_bal_out = m_bal[s]; end
    end else if (o == 3) begin
      if (m_bal[s] + amt > BAL_MAX) e = 5;
      else begin m_bal[s] += amt; m_bal_out = m_bal[s]; end
    end else if (o == 4) begin
      x = d - BASE;
      if (x < 0 || x >= NUM)       e = 1;
      else if (x == s)             e = 7;
      else if (amt > m_bal[s])     e = 4;
      else if (m_bal[x] + amt > BAL_MAX) e = 5;
      else begin
        m_bal[s] -= amt; m_bal[x] += amt; m_bal_out = m_bal[s];
      end
    end else begin
      if (p != m_pin[s]) begin
        e = 2; m_fail[s]++;
        if (m_fail[s] >= TRIES) begin
          m_lock[s] = 1; m_logged = 0; m_bal_out = 0; m_locked = 1;
        end
      end else m_pin[s] = np;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; exit = 1'b0;
    @(negedge clk);
    model_reset();
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_logged_in", logged_in, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_balance", balance, 0);
    rst = 1'b0;
  endtask

  task automatic do_exit();
    @(negedge clk);
    exit = 1'b1;
    @(posedge clk);
    #1 exit = 1'b0;
    model_exit();
    @(negedge clk);
    check_eq("exit_logged_in", logged_in, m_logged);
    check_eq("exit_locked", locked, m_locked);
    check_eq("exit_balance", balance, m_bal_out);
  endtask

  // xe / xb: literal expectations from a scenario, or -1 to rely on the model only
  task automatic do_op(input int o, input int a, input int p, input int d, input int amt,
                       input int np, input bit poke, input int xe, input int xb);
    int e, cyc;
    @(negedge clk);
    start = 1'b1; exit = 1'b0; op = 3'(o); acc_number = ACC_W'(a); pin = PIN_W'(p);
    dest_acc_number = ACC_W'(d); amount = BAL_W'(amt); new_pin = PIN_W'(np);
    model_op(o, a, p, d, amt, np, e);
    @(posedge clk);
    #1;
    start = poke; op = 3'($urandom); acc_number = ACC_W'($urandom); pin = PIN_W'($urandom);
    dest_acc_number = ACC_W'($urandom); amount = BAL_W'($urandom); new_pin = PIN_W'($urandom);
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    check_eq("latency", cyc, 3);
    check_eq("busy_hold", busy, 1);
    check_eq("err_code", err_code, e);
    check_eq("error", error, (e != 0));
    check_eq("logged_in", logged_in, m_logged);
    check_eq("locked", locked, m_locked);
    check_eq("balance", balance, m_bal_out);
    if (xe >= 0) check_eq("plan_err", err_code, xe);
    if (xb >= 0) check_eq("plan_bal", balance, xb);
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("busy_clear", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seen, o, a, p, d, amt, np, r, t;
    model_reset();
    do_reset();

    do_op(0, 2178, 4, 0, 0, 0, 0, 0, 500);
    do_op(2, 0, 0, 0, 100, 0, 0, 0, 400);
    do_op(2, 0, 0, 0, 2000, 0, 0, 4, 400);
    do_op(4, 0, 0, 2180, 50, 0, 0, 0, 350);
    do_exit();
    do_op(0, 2180, 6, 0, 0, 0, 0, 0, 550);
    do_op(4, 0, 0, 2180, 10, 0, 0, 7, 550);
    do_op(3, 0, 0, 0, 1500, 0, 0, 5, 550);
    do_op(3, 0, 0, 0, 1497, 0, 0, 0, 2047);

    repeat (3) do_op(0, 2177, 0, 0, 0, 0, 0, 2, 0);
    check_eq("plan_locked", locked, 1);
    do_op(0, 2177, 3, 0, 0, 0, 0, 3, 0);
    do_reset();
    do_op(0, 2177, 3, 0, 0, 0, 0, 0, 500);

    do_exit();
    do_op(1, 0, 0, 0, 0, 0, 0, 6, 0);

    @(negedge clk);
    start = 1'b1; exit = 1'b1; op = 3'd0; acc_number = ACC_W'(2178); pin = PIN_W'(4);
    @(posedge clk);
    #1 start = 1'b0; exit = 1'b0;
    model_exit();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check_eq("exit_start_nodone", seen, 0);
    check_eq("exit_start_logged", logged_in, 0);

    do_op(0, 2179, 5, 0, 0, 0, 1, 0, 500);
    do_op(6, 0, 0, 0, 0, 0, 0, 7, 500);
    do_op(5, 0, 5, 0, 0, 9, 0, 0, 500);
    do_exit();
    do_op(0, 2179, 9, 0, 0, 0, 0, 0, 500);

    do_op(0, 2178, 4, 0, 0, 0, 0, 0, 500);
    @(negedge clk);
    start = 1'b1; op = 3'd4; dest_acc_number = ACC_W'(2179); amount = BAL_W'(100);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_exec_done", done, 0);
    check_eq("rst_exec_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_op(0, 2178, 4, 0, 0, 0, 0, 0, 500);
    do_op(4, 0, 0, 2179, 0, 0, 0, 0, 500);
    do_exit();
    do_op(0, 2179, 5, 0, 0, 0, 0, 0, 500);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4) do_exit();
      else if (r < 6) do_reset();
      else begin
        if (m_logged == 0 && $urandom_range(0, 3) != 0) o = 0;
        else begin
          t = $urandom_range(0, 19);
          o = (t < 18) ? (t % 6) : (6 + t - 18);
        end
        a = BASE - 1 + $urandom_range(0, NUM + 1);
        t = a - BASE;
        if (o == 5) p = ($urandom_range(0, 3) != 0) ? m_pin[m_sess] : $urandom_range(0, 15);
        else if (t >= 0 && t < NUM && $urandom_range(0, 3) != 0) p = m_pin[t];
        else p = $urandom_range(0, 15);
        d = ($urandom_range(0, 5) == 0) ? BASE + m_sess : BASE - 1 + $urandom_range(0, NUM + 1);
        amt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 300) : $urandom_range(0, BAL_MAX);
        if ($urandom_range(0, 9) == 0) amt = 0;
        np = $urandom_range(0, 15);
        do_op(o, a, p, d, amt, np, 1'($urandom_range(0, 1)), -1, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
